// File: rtl/phy_pkg.sv
// Shared definitions for the SERDES PHY: aligner FSM states, the link training
// word (also used by the transmit-side pattern generator) and counter widths.
package phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } phy_state_e;

  localparam logic [7:0] PHY_TRAIN_PATTERN = 8'h5C;
  localparam int         SLIP_CNT_W        = 5;
  localparam int         MATCH_CNT_W       = 4;

endpackage

// File: rtl/phy_in_pattern_match.sv
// Training-word comparator with a registered consecutive-match counter; lock_hit_o
// pulses on the cycle the MATCH_COUNT-th consecutive matching word is seen.
module phy_in_pattern_match import phy_pkg::*; #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = PHY_TRAIN_PATTERN,
  parameter int                    MATCH_COUNT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  match_o,
  output logic                  lock_hit_o
);

  logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;

  assign match_o    = (data_i == TRAIN_PATTERN);
  assign lock_hit_o = en_i && match_o && (cnt_q == MATCH_CNT_W'(MATCH_COUNT - 1));

  // The run restarts whenever checking is suspended, a word mismatches or lock is declared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || !match_o || lock_hit_o) cnt_d = '0;
    else                                         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phy_in_align.sv
// Receive word aligner: pulses BITSLIP until the training word lands on the word
// boundary, then forwards aligned data. PHY_IN_LOCK_MON_EN adds a lock monitor with auto-retrain.
module phy_in_align import phy_pkg::*; #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = PHY_TRAIN_PATTERN,
  parameter int                    MATCH_COUNT   = 4,
  parameter int                    SLIP_WAIT     = 3,
  parameter int                    MAX_SLIPS     = 16
) (
  input  logic                  clk_div_in,
  input  logic                  reset_n,
  input  logic                  train_start,
`ifdef PHY_IN_LOCK_MON_EN
  input  logic                  train_active,
`endif
  input  logic [DATA_WIDTH-1:0] data_from_serdes,
  output logic                  bitslip,
  output logic [DATA_WIDTH-1:0] data_to_fabric,
  output logic                  data_valid,
  output logic                  aligned,
  output logic                  align_fail,
  output logic [SLIP_CNT_W-1:0] slip_count
);

  localparam int SETTLE_W = $clog2(SLIP_WAIT + 1);

  phy_state_e            state_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic [SLIP_CNT_W-1:0] slip_q;
  logic                  bitslip_q;
  logic                  aligned_q;
  logic                  fail_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  match;
  logic                  lock_hit;
`ifdef PHY_IN_LOCK_MON_EN
  logic [3:0]            err_q;
`endif

  phy_in_pattern_match #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TRAIN_PATTERN(TRAIN_PATTERN),
    .MATCH_COUNT  (MATCH_COUNT)
  ) u_match (
    .clk_i     (clk_div_in),
    .rst_ni    (reset_n),
    .en_i      (state_q == CHECK),
    .clr_i     (train_start),
    .data_i    (data_from_serdes),
    .match_o   (match),
    .lock_hit_o(lock_hit)
  );

  always_ff @(posedge clk_div_in or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_from_serdes;
  end

  // bitslip_q is raised on entry to SLIP, so the pulse spans exactly the SLIP cycle.
  always_ff @(posedge clk_div_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
`ifdef PHY_IN_LOCK_MON_EN
      err_q     <= '0;
`endif
    end else begin
      bitslip_q <= 1'b0;
      if (train_start) begin
        state_q   <= SETTLE;
        settle_q  <= '0;
        slip_q    <= '0;
        aligned_q <= 1'b0;
        fail_q    <= 1'b0;
`ifdef PHY_IN_LOCK_MON_EN
        err_q     <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: ;
          SETTLE: begin
            if (settle_q == SETTLE_W'(SLIP_WAIT - 1)) begin
              settle_q <= '0;
              state_q  <= CHECK;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          CHECK: begin
            if (lock_hit) begin
              state_q   <= LOCKED;
              aligned_q <= 1'b1;
            end else if (!match) begin
              if (slip_q == SLIP_CNT_W'(MAX_SLIPS)) begin
                state_q <= FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q   <= SLIP;
                bitslip_q <= 1'b1;
                slip_q    <= slip_q + 1'b1;
              end
            end
          end
          SLIP: state_q <= SETTLE;
          LOCKED: begin
`ifdef PHY_IN_LOCK_MON_EN
            if (train_active) begin
              if (match) begin
                err_q <= '0;
              end else if (err_q == 4'd7) begin
                err_q     <= '0;
                aligned_q <= 1'b0;
                slip_q    <= '0;
                settle_q  <= '0;
                state_q   <= SETTLE;
              end else begin
                err_q <= err_q + 1'b1;
              end
            end
`endif
          end
          FAIL: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bitslip        = bitslip_q;
  assign data_to_fabric = data_q;
  assign data_valid     = aligned_q;
  assign aligned        = aligned_q;
  assign align_fail     = fail_q;
  assign slip_count     = slip_q;

endmodule
